// File: rtl/step_move_scheduler.sv
// Two-axis coordinated STEP/DIR move sequencer with Bresenham interpolation.
// Optional DIR-to-STEP setup phase enabled by defining STEP_DIR_SETUP_EN.
module step_move_scheduler #(
    parameter int CNT_W         = 32,
    parameter int DIV_W         = 16,
    parameter int PULSE_CYC     = 4,
    parameter int DIR_SETUP_CYC = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] steps1,
    input  logic             dir1,
    input  logic [CNT_W-1:0] steps2,
    input  logic             dir2,
    input  logic [DIV_W-1:0] period,
    input  logic             abort,
    output logic             step1_out,
    output logic             dir1_out,
    output logic             step2_out,
    output logic             dir2_out,
    output logic             busy,
    output logic             done,
    output logic             aborted
);
    localparam int PW = $clog2(PULSE_CYC + 1);
    localparam int SW = $clog2(DIR_SETUP_CYC + 1);
    localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(PULSE_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_DONE} state_t;

    state_t                  state_reg, state_next;
    logic [CNT_W-1:0]        major_reg, major_next;
    logic [CNT_W-1:0]        minor_reg, minor_next;
    logic [CNT_W-1:0]        remaining_reg, remaining_next;
    logic signed [CNT_W:0]   err_reg, err_next, err_sub;
    logic [DIV_W-1:0]        eff_reg, eff_next;
    logic [DIV_W-1:0]        tick_cnt_reg, tick_cnt_next;
    logic [PW-1:0]           pulse_cnt_reg, pulse_cnt_next;
    logic [SW-1:0]           setup_cnt_reg, setup_cnt_next;
    logic                    major2_reg, major2_next;
    logic                    dir1_reg, dir1_next, dir2_reg, dir2_next;
    logic                    aborting_reg, aborting_next;
    logic [1:0]              step_reg, step_next, fire;
    logic                    transfer, tick, minor_fire, cmd_major2;
    logic [CNT_W-1:0]        cmd_major, cmd_minor;

    assign transfer   = cmd_valid && (state_reg == S_IDLE);
    // Tie goes to axis 1 as major
    assign cmd_major2 = steps2 > steps1;
    assign cmd_major  = cmd_major2 ? steps2 : steps1;
    assign cmd_minor  = cmd_major2 ? steps1 : steps2;
    assign err_sub    = err_reg - $signed({1'b0, minor_reg});

    always_comb begin
        state_next     = state_reg;
        major_next     = major_reg;
        minor_next     = minor_reg;
        remaining_next = remaining_reg;
        err_next       = err_reg;
        eff_next       = eff_reg;
        tick_cnt_next  = tick_cnt_reg;
        setup_cnt_next = setup_cnt_reg;
        major2_next    = major2_reg;
        dir1_next      = dir1_reg;
        dir2_next      = dir2_reg;
        aborting_next  = aborting_reg;
        tick           = 1'b0;
        minor_fire     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (transfer) begin
                    major2_next    = cmd_major2;
                    major_next     = cmd_major;
                    minor_next     = cmd_minor;
                    remaining_next = cmd_major;
                    err_next       = $signed({1'b0, cmd_major >> 1});
                    eff_next       = (period < MIN_PERIOD) ? MIN_PERIOD : period;
                    tick_cnt_next  = '0;
                    setup_cnt_next = SW'(DIR_SETUP_CYC - 1);
                    aborting_next  = 1'b0;
                    dir1_next      = dir1;
                    dir2_next      = dir2;
                    if (cmd_major == '0)
                        state_next = S_DONE;
                    else
`ifdef STEP_DIR_SETUP_EN
                        state_next = S_SETUP;
`else
                        state_next = S_RUN;
`endif
                end
            end
            S_SETUP: begin
                if (abort) begin
                    aborting_next = 1'b1;
                    state_next    = S_DONE;
                end else if (setup_cnt_reg == '0) begin
                    state_next = S_RUN;
                end else begin
                    setup_cnt_next = setup_cnt_reg - 1'b1;
                end
            end
            S_RUN: begin
                if (abort)
                    aborting_next = 1'b1;
                if (!abort && !aborting_reg && remaining_reg != '0 && tick_cnt_reg == '0) begin
                    tick           = 1'b1;
                    tick_cnt_next  = eff_reg - 1'b1;
                    remaining_next = remaining_reg - 1'b1;
                    if (err_sub[CNT_W]) begin
                        err_next   = err_sub + $signed({1'b0, major_reg});
                        minor_fire = 1'b1;
                    end else begin
                        err_next = err_sub;
                    end
                end else if (tick_cnt_reg != '0) begin
                    tick_cnt_next = tick_cnt_reg - 1'b1;
                end
                // Leave only once in-flight pulses have finished their full width
                if ((remaining_reg == '0 || abort || aborting_reg) && step_reg == 2'b00)
                    state_next = S_DONE;
            end
            S_DONE: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign fire[0] = major2_reg ? minor_fire : tick;
    assign fire[1] = major2_reg ? tick : minor_fire;

    // Both axes start together on a tick, so one shared width counter suffices
    assign pulse_cnt_next = tick ? PW'(PULSE_CYC - 1)
                          : (pulse_cnt_reg != '0) ? pulse_cnt_reg - 1'b1 : pulse_cnt_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_axis
            assign step_next[gi] = fire[gi] || (step_reg[gi] && pulse_cnt_reg != '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg     <= S_IDLE;
            major_reg     <= '0;
            minor_reg     <= '0;
            remaining_reg <= '0;
            err_reg       <= '0;
            eff_reg       <= '0;
            tick_cnt_reg  <= '0;
            pulse_cnt_reg <= '0;
            setup_cnt_reg <= '0;
            major2_reg    <= 1'b0;
            dir1_reg      <= 1'b0;
            dir2_reg      <= 1'b0;
            aborting_reg  <= 1'b0;
            step_reg      <= 2'b00;
        end else begin
            state_reg     <= state_next;
            major_reg     <= major_next;
            minor_reg     <= minor_next;
            remaining_reg <= remaining_next;
            err_reg       <= err_next;
            eff_reg       <= eff_next;
            tick_cnt_reg  <= tick_cnt_next;
            pulse_cnt_reg <= pulse_cnt_next;
            setup_cnt_reg <= setup_cnt_next;
            major2_reg    <= major2_next;
            dir1_reg      <= dir1_next;
            dir2_reg      <= dir2_next;
            aborting_reg  <= aborting_next;
            step_reg      <= step_next;
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign aborted   = (state_reg == S_DONE) && aborting_reg;
    assign step1_out = step_reg[0];
    assign step2_out = step_reg[1];
    assign dir1_out  = dir1_reg;
    assign dir2_out  = dir2_reg;
endmodule
